// File: rtl/brightness_ram_sequencer_pkg.sv
// Shared types, constants and the saturating pixel adder used by the
// brightness sequencer and the systolic PE.
package brightness_pkg;

    // Pixel width the shared arithmetic is built for.
    localparam int PIX_W = 8;

    // Largest representable pixel value.
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Unsigned pixel plus signed offset, clamped to [0, PIX_MAX].
    // The sum is formed two bits wider than the pixel. Bit PIX_W+1 is the
    // sign, and bit PIX_W flags an overflow past PIX_MAX. The worst case is
    // PIX_MAX + PIX_MAX, which still fits without reaching the sign bit.
    function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] pixel,
                                                 input logic [PIX_W:0]   offset);
        logic [PIX_W+1:0] sum;
        sum = {2'b00, pixel} + {offset[PIX_W], offset};
        if (sum[PIX_W+1]) begin
            sat_add = '0;
        end else if (sum[PIX_W]) begin
            sat_add = PIX_MAX;
        end else begin
            sat_add = sum[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/brightness_ram_sequencer_if.sv
// Control and RAM-bus bundle of the brightness sequencer.
//
// Handshake: start is a level that is sampled only while the sequencer is
// idle. busy is high from the accepting edge until done. done is a one-cycle
// pulse in which busy is already low. There is no backpressure. The source
// RAM returns src_q one cycle after it latches src_address. The destination
// RAM writes dst_data to dst_address on every edge where dst_wren is high.
interface brightness_ram_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W:0]   offset;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] src_address;
    logic              src_wren;
    logic [DATA_W-1:0] src_data;
    logic [DATA_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_address;
    logic [DATA_W-1:0] dst_data;
    logic              dst_wren;

    // Sequencer side.
    modport master (
        input  start, offset, src_q,
        output busy, done, src_address, src_wren, src_data,
               dst_address, dst_data, dst_wren
    );

    // Environment side: the controller plus both RAMs.
    modport slave (
        output start, offset, src_q,
        input  busy, done, src_address, src_wren, src_data,
               dst_address, dst_data, dst_wren
    );
endinterface

// File: rtl/brightness_ram_sequencer_alu.sv
// Combinational brightness adjust of one pixel, used in pipeline stage 2.
module brightness_pixel_alu
    import brightness_pkg::*;
(
    input  logic [PIX_W-1:0] pixel_i,
    input  logic [PIX_W:0]   offset_i,
    output logic [PIX_W-1:0] pixel_o
);

    assign pixel_o = sat_add(pixel_i, offset_i);

endmodule

// File: rtl/brightness_ram_sequencer.sv
// Streams NUM_WORDS words from the source RAM through the saturating
// brightness adder and into the destination RAM, one read per cycle.
module brightness_ram_sequencer
    import brightness_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 64
) (
    input  logic                         clock,
    input  logic                         reset_n,
    brightness_ram_sequencer_if.master   bus,
    output seq_state_t                   dbg_state_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    seq_state_t        state_q, state_d;
    logic [DATA_W:0]   offset_q, offset_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    // issue_q: the address now on src_address is a fresh read request.
    logic              issue_q, issue_d;
    // pipe_q[0]: the RAM has latched the address, so src_q is valid now.
    // pipe_q[1]: the adjusted word is on the destination bus.
    logic [1:0]        pipe_q;
    logic [ADDR_W-1:0] addr_d1_q;
    logic [ADDR_W-1:0] dst_addr_q;
    logic [DATA_W-1:0] dst_data_q;
    logic [DATA_W-1:0] alu_pixel;
    logic              busy;
    logic              done;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RUN moves on once the last address is issued.
    // DRAIN waits until no read is left in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (src_addr_d == LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (!issue_q && !pipe_q[0]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // Address counter, offset latch and issue flag. The counter saturates
    // at LAST_ADDR instead of wrapping, so a full 2^ADDR_W tile holds all-ones.
    always_comb begin
        src_addr_d = src_addr_q;
        offset_d   = offset_q;
        issue_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_addr_d = '0;
                    offset_d   = bus.offset;
                    issue_d    = 1'b1;
                end
            end
            RUN: begin
                if (src_addr_q != LAST_ADDR) begin
                    src_addr_d = src_addr_q + 1'b1;
                    issue_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control-path registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_addr_q <= '0;
            offset_q   <= '0;
            issue_q    <= 1'b0;
            pipe_q     <= 2'b00;
        end else begin
            src_addr_q <= src_addr_d;
            offset_q   <= offset_d;
            issue_q    <= issue_d;
            pipe_q     <= {pipe_q[0], issue_q};
        end
    end

    brightness_pixel_alu u_alu (
        .pixel_i (bus.src_q),
        .offset_i(offset_q),
        .pixel_o (alu_pixel)
    );

    // Address delay line and destination registers. Stage 1 remembers the
    // address the RAM latched. Stage 2 captures the adjusted read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_d1_q  <= '0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
        end else begin
            if (issue_q) begin
                addr_d1_q <= src_addr_q;
            end
            if (pipe_q[0]) begin
                dst_addr_q <= addr_d1_q;
                dst_data_q <= alu_pixel;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.src_address = src_addr_q;
    assign bus.src_wren    = 1'b0;
    assign bus.src_data    = '0;
    assign bus.dst_address = dst_addr_q;
    assign bus.dst_data    = dst_data_q;
    assign bus.dst_wren    = pipe_q[1];
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_brightness_ram_sequencer.sv
// Bench for brightness_ram_sequencer: behavioural RAMs, a write scoreboard
// and directed plus random tiles on a 64-word and a 1-word build.
module tb_brightness_ram_sequencer;
    import brightness_pkg::*;

    localparam int AW   = 6;
    localparam int DW   = 8;
    localparam int N    = 64;
    localparam logic [DW-1:0] SENT = 8'hA5;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    brightness_ram_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    brightness_ram_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    seq_state_t dbg, dbg1;

    brightness_ram_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus.master), .dbg_state_o(dbg)
    );

    brightness_ram_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1.master), .dbg_state_o(dbg1)
    );

    // ---------------- RAM models ----------------
    logic [DW-1:0] src_mem [64];
    logic [DW-1:0] dst_mem [64];
    logic [DW-1:0] src1_mem [64];
    logic [DW-1:0] dst1_mem [64];
    logic [AW-1:0] src_lat, src1_lat;
    logic          fill_dst = 1'b0;

    assign bus.src_q  = src_mem[src_lat];
    assign bus1.src_q = src1_mem[src1_lat];

    always @(posedge clock) begin
        src_lat <= bus.src_address;
        if (fill_dst) begin
            for (int i = 0; i < 64; i++) dst_mem[i] <= SENT;
        end else if (bus.dst_wren) begin
            dst_mem[bus.dst_address] <= bus.dst_data;
        end
    end

    always @(posedge clock) begin
        src1_lat <= bus1.src_address;
        if (bus1.dst_wren) dst1_mem[bus1.dst_address] <= bus1.dst_data;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int wren_total  = 0;
    int wren1_total = 0;
    logic [AW+DW-1:0] exp_q  [$];
    logic [AW+DW-1:0] exp1_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference arithmetic: plain integer add, then clamp to the pixel range.
    function automatic logic [DW-1:0] ref_pix(input int p, input int off);
        int s;
        s = p + off;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return DW'(s);
    endfunction

    // Monitor for the 64-word build.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.dst_wren) begin
                wren_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = exp_q.pop_front();
                    check("dst_address", int'(bus.dst_address), int'(e[AW+DW-1:DW]));
                    check("dst_data", int'(bus.dst_data), int'(e[DW-1:0]));
                end
            end
            if (bus.busy) check("src_bus_idle", int'({bus.src_wren, bus.src_data}), 0);
        end
    end

    // Monitor for the 1-word build.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus1.dst_wren) begin
                wren1_total++;
                if (exp1_q.size() == 0) begin
                    check("n1_unexpected_write", 1, 0);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = exp1_q.pop_front();
                    check("n1_dst_address", int'(bus1.dst_address), int'(e[AW+DW-1:DW]));
                    check("n1_dst_data", int'(bus1.dst_data), int'(e[DW-1:0]));
                end
            end
            if (bus1.busy) check("n1_src_address", int'(bus1.src_address), 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_src_address"}, int'(bus.src_address), 0);
        check({tag, "_src_wren"}, int'(bus.src_wren), 0);
        check({tag, "_src_data"}, int'(bus.src_data), 0);
        check({tag, "_dst_address"}, int'(bus.dst_address), 0);
        check({tag, "_dst_data"}, int'(bus.dst_data), 0);
        check({tag, "_dst_wren"}, int'(bus.dst_wren), 0);
        check({tag, "_state_idle"}, int'(dbg == IDLE), 1);
    endtask

    // One tile. busy_at >= 0 re-pulses start with new_off at that cycle.
    // reset_at >= 0 asserts reset at that cycle and ends the tile early.
    task automatic run_tile(input int off, input int busy_at, input int new_off,
                            input int reset_at);
        int  c;
        int  w0;
        bit  seen;
        for (int i = 0; i < N; i++)
            exp_q.push_back({AW'(i), ref_pix(int'(src_mem[i]), off)});
        @(negedge clock);
        bus.offset = 9'(off);
        bus.start  = 1'b1;
        w0 = wren_total;
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.offset = 9'($urandom_range(0, 511));
        check("e0_src_address", int'(bus.src_address), 0);
        check("e0_busy", int'(bus.busy), 1);
        c = 0;
        seen = 1'b0;
        while (!seen && c < 200) begin
            @(posedge clock);
            #1;
            c++;
            if (c == reset_at) begin
                reset_n = 1'b0;
                #1;
                check_all_zero("midrst");
                for (int i = 0; i < N; i++)
                    check("midrst_dst_mem", int'(dst_mem[i]),
                          (i < reset_at - 2) ? int'(ref_pix(int'(src_mem[i]), off)) : int'(SENT));
                exp_q.delete();
                @(negedge clock);
                reset_n = 1'b1;
                return;
            end
            check("src_address", int'(bus.src_address), (c < N) ? c : N - 1);
            if (bus.done) seen = 1'b1;
            else check("busy", int'(bus.busy), 1);
            if (c == busy_at) begin
                bus.start  = 1'b1;
                bus.offset = 9'(new_off);
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("done_seen", int'(seen), 1);
        check("done_cycle", c, N + 2);
        check("done_busy_low", int'(bus.busy), 0);
        check("wren_count", wren_total - w0, N);
        check("queue_empty", exp_q.size(), 0);
        for (int i = 0; i < N; i++)
            check("dst_mem", int'(dst_mem[i]), int'(ref_pix(int'(src_mem[i]), off)));
        @(posedge clock);
        #1;
        check("done_pulse", int'(bus.done), 0);
        check("back_idle", int'(dbg == IDLE), 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            check("no_second_done", int'(bus.done), 0);
        end
    endtask

    task automatic run_one(input int off);
        int c;
        int w0;
        exp1_q.push_back({AW'(0), ref_pix(int'(src1_mem[0]), off)});
        @(negedge clock);
        bus1.offset = 9'(off);
        bus1.start  = 1'b1;
        w0 = wren1_total;
        @(posedge clock);
        #1;
        bus1.start = 1'b0;
        c = 0;
        while (!bus1.done && c < 20) begin
            @(posedge clock);
            #1;
            c++;
        end
        check("n1_done_cycle", c, 3);
        check("n1_wren_count", wren1_total - w0, 1);
        check("n1_dst_mem0", int'(dst1_mem[0]), int'(ref_pix(int'(src1_mem[0]), off)));
        check("n1_queue_empty", exp1_q.size(), 0);
        @(posedge clock);
        #1;
        check("n1_idle", int'(dbg1 == IDLE), 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.start   = 1'b0;
        bus.offset  = '0;
        bus1.start  = 1'b0;
        bus1.offset = '0;
        for (int i = 0; i < 64; i++) begin
            src_mem[i]  = DW'(4 * i);
            src1_mem[i] = DW'(200 + i);
        end
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        run_tile(40, -1, 0, -1);
        check("pos_dst54", int'(dst_mem[54]), 255);
        check("pos_dst10", int'(dst_mem[10]), 80);
        run_tile(-100, -1, 0, -1);
        check("neg_dst26", int'(dst_mem[26]), 4);
        check("neg_dst63", int'(dst_mem[63]), 152);
        run_tile(255, -1, 0, -1);
        run_tile(-256, -1, 0, -1);
        run_tile(0, -1, 0, -1);
        run_tile(60, 10, -200, -1);

        @(negedge clock);
        fill_dst = 1'b1;
        @(posedge clock);
        #1;
        fill_dst = 1'b0;
        run_tile(40, -1, 0, 20);
        run_tile(17, -1, 0, -1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) src_mem[i] = DW'($urandom_range(0, 255));
            run_tile(int'($urandom_range(0, 511)) - 256, -1, 0, -1);
        end

        run_one(30);
        run_one(-240);
        src1_mem[0] = DW'($urandom_range(0, 255));
        run_one(int'($urandom_range(0, 511)) - 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
